muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit beside the single-cycle ALU in the SCPU datapath.
- Owns the HI/LO register pair. Executes MULT/MULTU/DIV/DIVU iteratively and services MTHI/MTLO writes.
- Control issues an op with start and stalls the pipeline on busy. MFHI/MFLO read hi/lo directly.

---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue, MTHI/MTLO and HI/LO result signals
// between control/datapath (master) and the multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, A, B, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, A, B, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU owning HI/LO.
// Define MULDIV_MADD_EN to add the MADD/MADDU accumulate ops.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              busy_q;
  logic              done_q;

  logic              legal;
  logic              is_sgn;
  logic              run_div;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    legal = 1'b0;
    unique case (bus.op)
      3'b000, 3'b001,
      3'b010, 3'b011: legal = 1'b1;
`ifdef MULDIV_MADD_EN
      3'b100, 3'b101: legal = 1'b1;
`endif
      default:        legal = 1'b0;
    endcase
  end

  // Even op codes are the signed variants.
  assign is_sgn  = ~bus.op[0];
  assign run_div = (op_q[2:1] == 2'b01);
  assign abs_a   = (is_sgn && bus.A[XLEN-1]) ? -bus.A : bus.A;
  assign abs_b   = (is_sgn && bus.B[XLEN-1]) ? -bus.B : bus.B;

  // acc holds {partial, multiplier} or {remainder, quotient}.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                  + (acc[0] ? {1'b0, mag_a} : '0);
  assign div_top  = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_top - {1'b0, mag_b};

  always_comb begin
    acc_nxt = {mul_sum, acc[XLEN-1:1]};
    if (run_div) begin
      if (div_diff[XLEN])
        acc_nxt = {div_top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  // A zero divisor yields rem=|A|, so sign fix restores A.
  assign prod_s = (neg_a ^ neg_b) ? -acc : acc;
  assign rem_s  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign quo_s  = (mag_b == '0) ? '1 :
                  (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start && legal) begin
            op_q   <= bus.op;
            neg_a  <= is_sgn & bus.A[XLEN-1];
            neg_b  <= is_sgn & bus.B[XLEN-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            if (bus.op[2:1] == 2'b01)
              acc <= {{XLEN{1'b0}}, abs_a};
            else
              acc <= {{XLEN{1'b0}}, abs_b};
            cnt    <= CW'(XLEN - 1);
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FINISH;
        end
        FINISH: begin
          if (run_div) begin
            {hi_q, lo_q} <= {rem_s, quo_s};
          end else begin
`ifdef MULDIV_MADD_EN
            if (op_q[2])
              {hi_q, lo_q} <= {hi_q, lo_q} + prod_s;
            else
              {hi_q, lo_q} <= prod_s;
`else
            {hi_q, lo_q} <= prod_s;
`endif
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand sequences
// for busy/done timing, dropped requests, reset abort and MADD.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0BAD_F00D;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mtx(input logic h, input logic [31:0] d);
    bus.hi_we = h;
    bus.lo_we = ~h;
    bus.wdata = d;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;

    vecs[0]  = '{"mult_neg",   MULT,  32'hFFFFFFFD, 32'h7,
                 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"multu",      MULTU, 32'hFFFFFFFD, 32'h7,
                 32'h00000006, 32'hFFFFFFEB};
    vecs[2]  = '{"div_neg",    DIV,   32'hFFFFFFF9, 32'h2,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu",       DIVU,  32'h7,        32'h2,
                 32'h00000001, 32'h00000003};
    vecs[4]  = '{"divu_zero",  DIVU,  32'h5,        32'h0,
                 32'h00000005, 32'hFFFFFFFF};
    vecs[5]  = '{"div_ovf",    DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h00000000, 32'h80000000};
    vecs[6]  = '{"div_negb",   DIV,   32'h7,        32'hFFFFFFFE,
                 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{"div_zero_s", DIV,   32'hFFFFFFFB, 32'h0,
                 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{"mult_min",   MULT,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'h00000000};
    vecs[9]  = '{"multu_max",  MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[10] = '{"divu_big",   DIVU,  32'hFFFFFFFF, 32'h10,
                 32'h0000000F, 32'h0FFFFFFF};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.A     = '0;
    bus.B     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi",   bus.hi,   0);
    chk("rst_lo",   bus.lo,   0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);

    mtx(1'b1, 32'h12345678);
    chk("mthi", bus.hi, 32'h12345678);
    mtx(1'b0, 32'h9ABCDEF0);
    chk("mtlo", bus.lo, 32'h9ABCDEF0);

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(n);
      chk({vecs[i].name, "_cyc"}, n, 33);
      chk({vecs[i].name, "_done"}, bus.done, 1);
      chk({vecs[i].name, "_hi"}, bus.hi, vecs[i].hi);
      chk({vecs[i].name, "_lo"}, bus.lo, vecs[i].lo);
      @(negedge clk);
      chk({vecs[i].name, "_dclr"}, bus.done, 0);
    end

    // Start in the done cycle, with an MTHI on the same edge.
    start_op(MULTU, 32'h3, 32'h5);
    wait_done(n);
    chk("b2b_done", bus.done, 1);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h00000ABC;
    start_op(DIVU, 32'h7, 32'h2);
    bus.hi_we = 1'b0;
    chk("b2b_busy", bus.busy, 1);
    chk("b2b_mthi", bus.hi, 32'h00000ABC);
    wait_done(n);
    chk("b2b_cyc", n, 33);
    chk("b2b_hi",  bus.hi, 1);
    chk("b2b_lo",  bus.lo, 3);

    // Start and MTHI/MTLO while busy are dropped.
    start_op(MULTU, 32'h3, 32'h4);
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = DIVU;
    bus.A     = 32'd100;
    bus.B     = 32'd3;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEADDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(n);
    chk("ign_cyc", n, 27);
    chk("ign_hi",  bus.hi, 0);
    chk("ign_lo",  bus.lo, 12);
    @(negedge clk);
    chk("ign_idle", bus.busy, 0);

    // Reset mid-run aborts the op.
    start_op(MULT, 32'h5, 32'h5);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_hi",   bus.hi,   0);
    chk("abort_lo",   bus.lo,   0);
    chk("abort_busy", bus.busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort_quiet", seen, 0);

    // Op 110 is illegal in every build.
    mtx(1'b1, 32'h11111111);
    mtx(1'b0, 32'h22222222);
    start_op(3'b110, 32'h3, 32'h4);
    chk("ill110_busy", bus.busy, 0);
    @(negedge clk);
    chk("ill110_hi", bus.hi, 32'h11111111);
    chk("ill110_lo", bus.lo, 32'h22222222);

`ifdef MULDIV_MADD_EN
    mtx(1'b1, 32'h0);
    mtx(1'b0, 32'hFFFFFFFF);
    start_op(3'b101, 32'h1, 32'h1);
    wait_done(n);
    chk("maddu_cyc", n, 33);
    chk("maddu_hi", bus.hi, 1);
    chk("maddu_lo", bus.lo, 0);
    mtx(1'b1, 32'h0);
    mtx(1'b0, 32'h0);
    start_op(3'b100, 32'hFFFFFFFD, 32'h7);
    wait_done(n);
    chk("madd_cyc", n, 33);
    chk("madd_hi", bus.hi, 32'hFFFFFFFF);
    chk("madd_lo", bus.lo, 32'hFFFFFFEB);
`else
    start_op(3'b100, 32'h3, 32'h4);
    chk("ill100_busy", bus.busy, 0);
    @(negedge clk);
    chk("ill100_hi", bus.hi, 32'h11111111);
    chk("ill100_lo", bus.lo, 32'h22222222);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
